// File: rtl/pcie_tx_source.sv
// Upstream traffic source: stages host words in a circular buffer and pushes them
// into the device main FIFO, honouring MAIN_FIFO_pause with a resume delay.
module pcie_tx_source #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int CNT_W      = 8,
  parameter int RESUME_DLY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [5:0]       wr_data,
  output logic             wr_full,
  output logic [5:0]       data_out,
  output logic             push_out,
  input  logic             pause_in,
  output logic [CNT_W-1:0] cnt_d0,
  output logic [CNT_W-1:0] cnt_d1,
  output logic             overflow,
  output logic             idle
);

  localparam int RW = (RESUME_DLY < 2) ? 1 : $clog2(RESUME_DLY + 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [RW-1:0]   RES_MAX  = RW'(RESUME_DLY);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD} state_t;

  state_t            state, state_nxt;
  logic [5:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [RW-1:0]     resume_cnt, resume_nxt;
  logic              pop, push_nxt, wr_accept;

  // A full buffer still accepts a write when the same cycle pops the head.
  assign wr_accept = wr_en && ((count != FULL_CNT) || pop);
  assign wr_full   = (count == FULL_CNT);
  assign idle      = (state == S_IDLE) && (count == '0);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_nxt  = state;
    resume_nxt = resume_cnt;
    pop        = 1'b0;
    push_nxt   = 1'b0;
    unique case (state)
      S_IDLE: if (enable && (count != '0)) state_nxt = S_SEND;
      S_SEND: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (pause_in) begin
          state_nxt  = S_HOLD;
          resume_nxt = '0;
        end else if (count != '0) begin
          pop      = 1'b1;
          push_nxt = 1'b1;
          if ((count == 1) && !wr_en) state_nxt = S_IDLE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (pause_in) begin
          resume_nxt = '0;
        end else begin
          resume_nxt = resume_cnt + 1'b1;
          if (resume_nxt == RES_MAX) state_nxt = S_SEND;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the storage array carries no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      resume_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      push_out   <= 1'b0;
      cnt_d0     <= '0;
      cnt_d1     <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      resume_cnt <= resume_nxt;
      push_out   <= push_nxt;
      if (push_nxt)  data_out <= mem[rd_ptr];
      if (wr_accept) wr_ptr   <= wr_ptr + 1'b1;
      if (pop)       rd_ptr   <= rd_ptr + 1'b1;
      if (wr_accept && !pop)      count <= count + 1'b1;
      else if (!wr_accept && pop) count <= count - 1'b1;
      if (wr_en && !wr_accept) overflow <= 1'b1;
      // Counters follow the registered push, so they settle one clock after each pulse.
      if (push_out) begin
        if (data_out[4]) cnt_d1 <= cnt_d1 + 1'b1;
        else             cnt_d0 <= cnt_d0 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcie_tx_source.sv
// Directed self-checking bench for pcie_tx_source: pushed words are captured by a
// monitor and compared against a bench-built expected stream.
module tb_pcie_tx_source;

  localparam int RESUME_DLY = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_data = '0;
  logic       pause_in = 1'b0;
  logic       wr_full, push_out, overflow, idle;
  logic [5:0] data_out;
  logic [7:0] cnt_d0, cnt_d1;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [5:0] rx_q[$];
  logic [5:0] exp_q[$];
  int         stamp_q[$];

  pcie_tx_source #(.DEPTH(8), .ADDR_W(3), .CNT_W(8), .RESUME_DLY(RESUME_DLY)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .data_out(data_out), .push_out(push_out), .pause_in(pause_in),
    .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .overflow(overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (push_out) begin
      rx_q.push_back(data_out);
      stamp_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    enable   = 1'b0;
    wr_en    = 1'b0;
    pause_in = 1'b0;
    ticks(2);
    reset = 1'b1;
    rx_q.delete();
    stamp_q.delete();
    exp_q.delete();
  endtask

  task automatic put(input logic [5:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    exp_q.push_back(w);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    int n;
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, rx_q[i], exp_q[i]);
  endtask

  task automatic check_counts(input string tag);
    logic [7:0] d0, d1;
    d0 = '0;
    d1 = '0;
    foreach (exp_q[i]) begin
      if (exp_q[i][4]) d1 = d1 + 1'b1;
      else             d0 = d0 + 1'b1;
    end
    check({tag, "_cnt_d0"}, cnt_d0, d0);
    check({tag, "_cnt_d1"}, cnt_d1, d1);
  endtask

  initial begin
    // Reset state
    ticks(2);
    check("rst_push", push_out, 1'b0);
    check("rst_data", data_out, 6'h00);
    check("rst_cnt_d0", cnt_d0, 8'd0);
    check("rst_cnt_d1", cnt_d1, 8'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_full", wr_full, 1'b0);

    // 1: four words streamed back to back, no bypass from write to push
    do_reset();
    enable  = 1'b1;
    wr_en   = 1'b1;
    wr_data = 6'h05; exp_q.push_back(6'h05); tick();
    wr_data = 6'h15; exp_q.push_back(6'h15); tick();
    check("t1_no_bypass", push_out, 1'b0);
    wr_data = 6'h25; exp_q.push_back(6'h25); tick();
    check("t1_first_push", push_out, 1'b1);
    check("t1_first_data", data_out, 6'h05);
    wr_data = 6'h35; exp_q.push_back(6'h35); tick();
    wr_en = 1'b0;
    ticks(6);
    check_stream("t1");
    if (stamp_q.size() >= 4) check("t1_consecutive", stamp_q[3] - stamp_q[0], 3);
    else                     check("t1_pulses", stamp_q.size(), 4);
    check_counts("t1");
    check("t1_idle", idle, 1'b1);

    // 2: nine writes into an eight-entry buffer while disabled
    do_reset();
    for (int i = 0; i < 8; i++) put(6'(i * 5 + 1));
    check("t2_full", wr_full, 1'b1);
    check("t2_no_ovf_yet", overflow, 1'b0);
    wr_en = 1'b1; wr_data = 6'h3F; tick(); wr_en = 1'b0;
    check("t2_overflow", overflow, 1'b1);
    enable = 1'b1;
    ticks(14);
    check_stream("t2");
    check_counts("t2");
    check("t2_ovf_sticky", overflow, 1'b1);
    check("t2_idle", idle, 1'b1);

    // 3: one-cycle pause mid-stream
    do_reset();
    for (int i = 0; i < 6; i++) put(6'(8'h30 + 8'(i * 7)));
    enable = 1'b1;
    tick();
    tick();
    check("t3_streaming", push_out, 1'b1);
    tick();
    pause_in = 1'b1;
    tick();
    check("t3_pause_stop", push_out, 1'b0);
    pause_in = 1'b0;
    ticks(10);
    check_stream("t3");
    if (stamp_q.size() >= 3) check("t3_resume_gap", stamp_q[2] - stamp_q[1], 2 + RESUME_DLY);
    else                     check("t3_pulses", stamp_q.size(), 6);
    check_counts("t3");

    // 4: write into a full buffer on the same cycle as a pop
    do_reset();
    for (int i = 0; i < 8; i++) put(6'(8'h10 + 8'(i * 3)));
    check("t4_full", wr_full, 1'b1);
    enable = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 6'h2A; exp_q.push_back(6'h2A);
    tick();
    wr_en = 1'b0;
    check("t4_no_overflow", overflow, 1'b0);
    check("t4_still_full", wr_full, 1'b1);
    ticks(14);
    check_stream("t4");
    check("t4_ovf_final", overflow, 1'b0);

    // 5: reset while sending with five words still buffered
    do_reset();
    for (int i = 0; i < 7; i++) put(6'(i + 2));
    enable = 1'b1;
    ticks(3);
    check("t5_sending", push_out, 1'b1);
    reset = 1'b0;
    tick();
    check("t5_push_cleared", push_out, 1'b0);
    check("t5_data_cleared", data_out, 6'h00);
    check("t5_cnt_d0", cnt_d0, 8'd0);
    check("t5_cnt_d1", cnt_d1, 8'd0);
    check("t5_idle", idle, 1'b1);
    reset = 1'b1;
    rx_q.delete();
    ticks(10);
    check("t5_no_stale", rx_q.size(), 0);
    check("t5_idle_after", idle, 1'b1);

    // 6: 300 words with bit4 clear, counter wraps
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [8:0] iv;
      iv = 9'(i);
      wr_en   = 1'b1;
      wr_data = {iv[4], 1'b0, iv[3:0]};
      exp_q.push_back({iv[4], 1'b0, iv[3:0]});
      tick();
    end
    wr_en = 1'b0;
    ticks(8);
    check_stream("t6");
    check_counts("t6");
    check("t6_wrap_value", cnt_d0, 8'd44);
    check("t6_no_overflow", overflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
